// File: rtl/gray_counter.sv
// gray_counter
//   Parametrised binary/Gray up/down counter with a registered Gray-to-binary
//   decode port. Every output comes straight from a flop. The Gray code is
//   computed from the next binary value and registered on the same edge, so
//   bin and gray never skew. On each enabled step gray changes in exactly one
//   bit, which makes it safe to use as a pointer crossing clock domains.
//
//   Ports
//     clk       in   single clock, rising edge
//     rst       in   synchronous active-high reset
//     en        in   count enable, one step per cycle
//     up        in   direction: 1 up, 0 down
//     load      in   synchronous load of load_bin (beats en)
//     load_bin  in   [WIDTH] binary value to load
//     gray_in   in   [WIDTH] Gray code to decode
//     bin       out  [WIDTH] registered binary count
//     gray      out  [WIDTH] registered Gray code of bin
//     wrap      out  one-cycle pulse on terminal-count rollover
//     bin_dec   out  [WIDTH] registered binary decode of gray_in
//
//   Priority on each edge: rst > load > en > hold.
//   WIDTH must be in the range 2..16.

module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap,
   output logic [WIDTH-1:0] bin_dec
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] bin_dec_q, bin_dec_d;

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_bin;
      end else if (en) begin
         if (up) begin
            bin_d  = bin_q + ONE;
            wrap_d = &bin_q;
         end else begin
            bin_d  = bin_q - ONE;
            wrap_d = ~|bin_q;
         end
      end
   end

   // Encode from the next count, not from bin_q, so gray lands on the same
   // edge as bin.
   always_comb begin
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // Prefix XOR from the MSB downwards.
   always_comb begin
      bin_dec_d            = '0;
      bin_dec_d[WIDTH-1]   = gray_in[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bin_dec_d[i] = bin_dec_d[i+1] ^ gray_in[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q     <= '0;
         gray_q    <= '0;
         wrap_q    <= 1'b0;
         bin_dec_q <= '0;
      end else begin
         bin_q     <= bin_d;
         gray_q    <= gray_d;
         wrap_q    <= wrap_d;
         bin_dec_q <= bin_dec_d;
      end
   end

   assign bin     = bin_q;
   assign gray    = gray_q;
   assign wrap    = wrap_q;
   assign bin_dec = bin_dec_q;

endmodule
